// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA read side: 640x480@60 timing,
// the 160x120 framebuffer geometry and the 18-bit pixel word layout.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_ADDR_W = 15;

  localparam int COLOUR_BITS = 6;
  localparam int PIX_W       = 3 * COLOUR_BITS;
  localparam int R_LSB       = 2 * COLOUR_BITS;
  localparam int G_LSB       = COLOUR_BITS;
  localparam int B_LSB       = 0;
  localparam int DAC_W       = 10;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_flags_t;

  localparam vga_flags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  // Replicating the top bits keeps full-scale 6-bit values at full-scale 10-bit.
  function automatic logic [DAC_W-1:0] expand_channel(input logic [COLOUR_BITS-1:0] c);
    return {c, c[COLOUR_BITS-1 -: DAC_W-COLOUR_BITS]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running 640x480@60 timing: pixel enable, line/frame counters and the
// raw active/sync flags for the pixel position currently being issued.
module vga_timing
  import vga_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output vga_flags_t       flags
);

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  always_comb begin
    flags        = FLAGS_IDLE;
    flags.active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    flags.hs     = !((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST));
    flags.vs     = !((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST));
  end

  assign pix_en = pix_en_q;
  assign h_cnt  = h_cnt_q;
  assign v_cnt  = v_cnt_q;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: turns the timing counters into 160x120 RAM reads and
// drives the VGA DAC with each stored pixel upscaled 4x4.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int BITS_PER_COLOUR_CHANNEL = COLOUR_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [FB_ADDR_W-1:0] rd_addr,
  output logic                 rd_en,
  input  logic [PIX_W-1:0]     rd_data,
  output logic                 frame_start,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 VGA_SYNC_N,
  output logic [DAC_W-1:0]     VGA_R,
  output logic [DAC_W-1:0]     VGA_G,
  output logic [DAC_W-1:0]     VGA_B
);

  if (BITS_PER_COLOUR_CHANNEL != COLOUR_BITS) begin : g_bad_colour_width
    $error("vga_scanout: BITS_PER_COLOUR_CHANNEL must be %0d", COLOUR_BITS);
  end

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  vga_flags_t       flags;

  vga_timing u_timing (
    .clock  (clock),
    .reset  (reset),
    .pix_en (pix_en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .flags  (flags)
  );

  logic [FB_ADDR_W-1:0] h_ext, v_ext, fb_addr;
  logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_en_q, rd_en_d;
  logic                 frame_start_q, frame_start_d;
  vga_flags_t           flags_q, flags_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 blank_n_q, blank_n_d;
  logic [DAC_W-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;

  // y*160 built as y*128 + y*32 so no multiplier is inferred.
  always_comb begin
    h_ext   = FB_ADDR_W'(h_cnt);
    v_ext   = FB_ADDR_W'(v_cnt);
    fb_addr = ((v_ext >> 2) << 7) + ((v_ext >> 2) << 5) + (h_ext >> 2);
  end

  always_comb begin
    rd_addr_d     = rd_addr_q;
    rd_en_d       = 1'b0;
    frame_start_d = 1'b0;
    flags_d       = flags_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    if (pix_en) begin
      rd_en_d       = flags.active;
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      flags_d       = flags;
      if (flags.active) begin
        rd_addr_d = fb_addr;
      end
      // Flags issued one pixel ago line up with the word the RAM returned since.
      hs_d      = flags_q.hs;
      vs_d      = flags_q.vs;
      blank_n_d = flags_q.active;
      r_d       = '0;
      g_d       = '0;
      b_d       = '0;
      if (flags_q.active) begin
        r_d = expand_channel(rd_data[R_LSB +: COLOUR_BITS]);
        g_d = expand_channel(rd_data[G_LSB +: COLOUR_BITS]);
        b_d = expand_channel(rd_data[B_LSB +: COLOUR_BITS]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_q     <= '0;
      rd_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      flags_q       <= FLAGS_IDLE;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      rd_addr_q     <= rd_addr_d;
      rd_en_q       <= rd_en_d;
      frame_start_q <= frame_start_d;
      flags_q       <= flags_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign rd_en       = rd_en_q;
  assign frame_start = frame_start_q;
  assign VGA_CLK     = pix_en;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule
